// File: rtl/sad_disparity_pipeline.sv
// sad_disparity_pipeline: four-stage stereo SAD matcher with a sliding window over columns.
// Ports: clock_i/reset_i (sync, active-high); in_valid_i/line_start_i tag each column;
// in_left_i carries one left column, in_right_i carries NUM_DISP candidate right columns;
// out_valid_o/out_disp_o/out_sad_o report the winning disparity and its window SAD;
// out_unique_o is the uniqueness flag. Define SAD_UNIQUENESS_EN to build second-best
// tracking; without it out_unique_o mirrors out_valid_o.
module sad_disparity_pipeline #(
   parameter int WINDOW_SIZE = 5,
   parameter int NUM_BITS = 8,
   parameter int NUM_DISP = 4,
   parameter int COL_BITS = 11,
   parameter int SUM_BITS = 14,
   parameter logic [SUM_BITS-1:0] UNIQ_THRESH = SUM_BITS'(16)
) (
   input  logic                                     clock_i,
   input  logic                                     reset_i,
   input  logic                                     in_valid_i,
   input  logic                                     line_start_i,
   input  logic [NUM_BITS*WINDOW_SIZE-1:0]          in_left_i,
   input  logic [NUM_BITS*WINDOW_SIZE*NUM_DISP-1:0] in_right_i,
   output logic                                     out_valid_o,
   output logic [$clog2(NUM_DISP)-1:0]              out_disp_o,
   output logic [SUM_BITS-1:0]                      out_sad_o,
   output logic                                     out_unique_o
);
   localparam int DW = $clog2(NUM_DISP);
   localparam int CW = $clog2(WINDOW_SIZE + 1);
   localparam int PW = NUM_BITS * WINDOW_SIZE;

   function automatic logic [NUM_BITS-1:0] absdiff(input logic [NUM_BITS-1:0] a, input logic [NUM_BITS-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   logic                v1_q, ls1_q, v2_q, ls2_q, v3_q, out_valid_q;
   logic [NUM_BITS-1:0] diff_d [NUM_DISP][WINDOW_SIZE];
   logic [NUM_BITS-1:0] diff_q [NUM_DISP][WINDOW_SIZE];
   logic [COL_BITS-1:0] col_d [NUM_DISP];
   logic [COL_BITS-1:0] col_q [NUM_DISP];
   logic [COL_BITS-1:0] hist_q [NUM_DISP][WINDOW_SIZE];
   logic [SUM_BITS-1:0] sum_d [NUM_DISP];
   logic [SUM_BITS-1:0] sum_q [NUM_DISP];
   logic [CW-1:0]       cnt_d, cnt_q;
   logic [DW-1:0]       best_idx_d, out_disp_q;
   logic [SUM_BITS-1:0] best_sad_d, out_sad_q;

   always_comb begin
      for (int d = 0; d < NUM_DISP; d++)
         for (int k = 0; k < WINDOW_SIZE; k++)
            diff_d[d][k] = absdiff(in_left_i[k*NUM_BITS +: NUM_BITS], in_right_i[d*PW + k*NUM_BITS +: NUM_BITS]);
   end

   always_comb begin
      for (int d = 0; d < NUM_DISP; d++) begin
         col_d[d] = '0;
         for (int k = 0; k < WINDOW_SIZE; k++)
            col_d[d] = col_d[d] + COL_BITS'(diff_q[d][k]);
      end
   end

   // A line_start column restarts the window: history and sums behave as if zeroed first.
   always_comb begin
      cnt_d = ls2_q ? CW'(1) : (cnt_q == CW'(WINDOW_SIZE)) ? cnt_q : cnt_q + CW'(1);
      for (int d = 0; d < NUM_DISP; d++)
         sum_d[d] = (ls2_q ? '0 : sum_q[d] - SUM_BITS'(hist_q[d][WINDOW_SIZE-1])) + SUM_BITS'(col_q[d]);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         v1_q  <= 1'b0;
         ls1_q <= 1'b0;
         v2_q  <= 1'b0;
         ls2_q <= 1'b0;
      end else begin
         v1_q  <= in_valid_i;
         ls1_q <= in_valid_i & line_start_i;
         v2_q  <= v1_q;
         ls2_q <= ls1_q;
      end
   end

   always_ff @(posedge clock_i) begin
      diff_q <= diff_d;
      col_q  <= col_d;
   end

   // hist_q[d][WINDOW_SIZE-1] is the column leaving the window on the next valid column.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         v3_q  <= 1'b0;
         for (int d = 0; d < NUM_DISP; d++) begin
            sum_q[d] <= '0;
            for (int k = 0; k < WINDOW_SIZE; k++)
               hist_q[d][k] <= '0;
         end
      end else begin
         v3_q <= v2_q && (cnt_d == CW'(WINDOW_SIZE));
         if (v2_q) begin
            cnt_q <= cnt_d;
            for (int d = 0; d < NUM_DISP; d++) begin
               sum_q[d]     <= sum_d[d];
               hist_q[d][0] <= col_q[d];
               for (int k = 1; k < WINDOW_SIZE; k++)
                  hist_q[d][k] <= ls2_q ? '0 : hist_q[d][k-1];
            end
         end
      end
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      best_idx_d = '0;
      best_sad_d = sum_q[0];
      for (int d = 1; d < NUM_DISP; d++)
         if (sum_q[d] < best_sad_d) begin
            best_sad_d = sum_q[d];
            best_idx_d = DW'(d);
         end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         out_valid_q <= 1'b0;
         out_disp_q  <= '0;
         out_sad_q   <= '0;
      end else begin
         out_valid_q <= v3_q;
         if (v3_q) begin
            out_disp_q <= best_idx_d;
            out_sad_q  <= best_sad_d;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_disp_o  = out_disp_q;
   assign out_sad_o   = out_sad_q;

`ifdef SAD_UNIQUENESS_EN
   logic [SUM_BITS-1:0] second_d;
   logic                uniq_d, out_unique_q;

   // Second best is the minimum over every other index, so an exact tie yields margin 0.
   always_comb begin
      second_d = '1;
      for (int d = 0; d < NUM_DISP; d++)
         if (DW'(d) != best_idx_d && sum_q[d] < second_d)
            second_d = sum_q[d];
      uniq_d = (second_d - best_sad_d) >= UNIQ_THRESH;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) out_unique_q <= 1'b0;
      else if (v3_q) out_unique_q <= uniq_d;
   end

   assign out_unique_o = out_unique_q;
`else
   assign out_unique_o = out_valid_q;
`endif
endmodule
